score_reporter: RTL and testbench
=================================

// Module: score_reporter
// PURPOSE
// - Producer end of the score_req/Score/playerID handshake consumed by the score tracker.
// - Accumulates the running score of the active player during a game. At game end it
//   presents the final score, holds the request long enough for the tracker to finish,
//   captures the personal_winner/global_winner verdict and releases the request.
// - Sits between the game-play FSM (start/tick/over events) and the score tracker.
// PARAMETERS
// - REQ_CODE      5     score_req value that means "score valid, process it"
// - MAX_SCORE     9999  saturation limit of the running score (fits the 14-bit bus)
// - HOLD_CYCLES   12    cycles score_req = REQ_CODE is held (>= tracker latency + 2)
// - RELEASE_CYCLES 2    cycles score_req = 0 is held before a new report is allowed
// PORTS
// - clk              in   1   system clock, all state on rising edge
// - rst              in   1   asynchronous, active-high reset
// - game_start       in   1   1-cycle pulse: begin a game for player_id_in
// - player_id_in     in   5   player ID, sampled on game_start
// - point_tick       in   1   1-cycle pulse: add one point to the running score
// - game_over        in   1   1-cycle pulse: end the game, start reporting
// - personal_winner  in   1   tracker verdict: new personal best
// - global_winner    in   1   tracker verdict: new global best
// - score_req        out  4   REQ_CODE while reporting, else 0
// - playerID         out  5   player ID of the current/last game
// - Score            out  14  running score (live during play, frozen while reporting)
// - busy             out  1   high in every state except IDLE
// - new_personal_best out 1   verdict latched at end of HOLD, held until next game_start
// - new_global_best  out  1   verdict latched at end of HOLD, held until next game_start
// - report_done      out  1   1-cycle pulse on leaving RELEASE
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, score_req=0, playerID=0, Score=0, busy=0,
//   new_personal_best=0, new_global_best=0, report_done=0, all counters 0.
// - States: IDLE, PLAYING, HOLD, RELEASE.
// - IDLE: game_start -> PLAYING; Score<=0, playerID<=player_id_in, both verdict flags <=0.
//   point_tick and game_over ignored.
// - PLAYING: point_tick -> Score+1, saturating at MAX_SCORE (never wraps).
//   game_over -> HOLD; score_req<=REQ_CODE next cycle, hold counter<=0.
//   point_tick and game_over in the same cycle: tick counted first, final Score includes it.
//   game_start in PLAYING ignored (no restart mid-game).
// - HOLD: score_req=REQ_CODE, Score/playerID frozen, inputs ignored; counter counts
//   HOLD_CYCLES cycles. On the last HOLD cycle sample personal_winner/global_winner into
//   new_personal_best/new_global_best, then -> RELEASE with score_req<=0.
// - RELEASE: score_req=0 for RELEASE_CYCLES cycles (guarantees the tracker sees a value
//   != REQ_CODE and re-arms); then report_done pulses 1 cycle and -> IDLE.
//   game_start during HOLD/RELEASE is dropped (not queued).
// - score_req only ever takes values 0 or REQ_CODE; transitions are registered (no glitch).
// - Latency: game_over edge to score_req=REQ_CODE: 1 cycle; request width exactly
//   HOLD_CYCLES; game_over to report_done: 1+HOLD_CYCLES+RELEASE_CYCLES cycles.
// - Reset mid-report: score_req drops to 0 asynchronously; tracker returns to idle via !=REQ_CODE.
// - Illegal state encoding: -> IDLE with all outputs at reset values.
// STRUCTURE
// - Shared package: state encodings, REQ_CODE, MAX_SCORE, score width (14), ID width (5).
// - One sub-module: score_accumulator (clear, inc, freeze -> 14-bit saturating count);
//   FSM, hold/release counter and verdict latches stay in score_reporter.
// TESTING
// - Basic: start id=3, 7 ticks, game_over -> score_req=5 for 12 cycles, Score=7, playerID=3.
// - Verdict: model tracker drives personal=1, global=0 by cycle 9 of HOLD ->
//   new_personal_best=1, new_global_best=0 after HOLD, report_done pulses once.
// - Saturation: 10005 ticks -> Score=9999 at game_over, no wrap to 0.
// - Simultaneous: tick and game_over same cycle at Score=41 -> reported Score=42.
// - Ignored events: game_start during PLAYING/HOLD, ticks during HOLD -> ID/Score unchanged.
// - Reset mid-HOLD -> score_req=0 same cycle (async), all outputs reset, IDLE accepts new start.

Source files
------------

// File: rtl/score_reporter_pkg.sv
// Shared widths, protocol constants and FSM encoding for the score reporter.
package score_reporter_pkg;
  localparam int SCORE_W = 14;
  localparam int ID_W    = 5;
  localparam int REQ_W   = 4;
  localparam int CNT_W   = 8;

  localparam logic [REQ_W-1:0] REQ_CODE_DEF       = 4'd5;
  localparam int               MAX_SCORE_DEF      = 9999;
  localparam int               HOLD_CYCLES_DEF    = 12;
  localparam int               RELEASE_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAYING = 2'd1,
    ST_HOLD    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;
endpackage

// File: rtl/score_reporter_accumulator.sv
// Saturating running-score counter: clear wins, freeze blocks increments.
module score_accumulator
  import score_reporter_pkg::*;
#(
  parameter int MAX_SCORE = MAX_SCORE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic               i_inc,
  input  logic               i_freeze,
  output logic [SCORE_W-1:0] o_score
);
  logic [SCORE_W-1:0] r_score;

  // Count points up to MAX_SCORE and stick there instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                               r_score <= '0;
    else if (i_clear)                                      r_score <= '0;
    else if (i_inc && !i_freeze && r_score < SCORE_W'(MAX_SCORE)) r_score <= r_score + 1'b1;
  end

  assign o_score = r_score;
endmodule

// File: rtl/score_reporter.sv
// Producer side of the score_req/Score/playerID handshake to the score tracker.
// Tracks the running score during a game, then holds the request for a fixed
// window, latches the tracker verdict and releases the request.
module score_reporter
  import score_reporter_pkg::*;
#(
  parameter logic [REQ_W-1:0] REQ_CODE       = REQ_CODE_DEF,
  parameter int               MAX_SCORE      = MAX_SCORE_DEF,
  parameter int               HOLD_CYCLES    = HOLD_CYCLES_DEF,
  parameter int               RELEASE_CYCLES = RELEASE_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               game_start,
  input  logic [ID_W-1:0]    player_id_in,
  input  logic               point_tick,
  input  logic               game_over,
  input  logic               personal_winner,
  input  logic               global_winner,
  output logic [REQ_W-1:0]   score_req,
  output logic [ID_W-1:0]    playerID,
  output logic [SCORE_W-1:0] Score,
  output logic               busy,
  output logic               new_personal_best,
  output logic               new_global_best,
  output logic               report_done
);
  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [REQ_W-1:0]   r_req, w_req_nxt;
  logic [ID_W-1:0]    r_pid, w_pid_nxt;
  logic               r_pb, w_pb_nxt;
  logic               r_gb, w_gb_nxt;
  logic               r_done, w_done_nxt;
  logic               w_clear, w_inc, w_freeze;

  // Score only moves while a game is in progress; it is frozen for the report.
  score_accumulator #(.MAX_SCORE(MAX_SCORE)) u_acc (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_clear),
    .i_inc   (w_inc),
    .i_freeze(w_freeze),
    .o_score (Score)
  );

  assign w_freeze = (r_state != ST_PLAYING);

  // Next-state and next-output logic; score_req is computed here and registered
  // so the tracker never sees an intermediate value.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_req_nxt   = '0;
    w_pid_nxt   = r_pid;
    w_pb_nxt    = r_pb;
    w_gb_nxt    = r_gb;
    w_done_nxt  = 1'b0;
    w_clear     = 1'b0;
    w_inc       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (game_start) begin
          w_state_nxt = ST_PLAYING;
          w_clear     = 1'b1;
          w_pid_nxt   = player_id_in;
          w_pb_nxt    = 1'b0;
          w_gb_nxt    = 1'b0;
        end
      end
      ST_PLAYING: begin
        // A tick coinciding with game_over still lands in the final score.
        w_inc = point_tick;
        if (game_over) begin
          w_state_nxt = ST_HOLD;
          w_req_nxt   = REQ_CODE;
          w_cnt_nxt   = '0;
        end
      end
      ST_HOLD: begin
        w_req_nxt = REQ_CODE;
        if (r_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
          w_pb_nxt    = personal_winner;
          w_gb_nxt    = global_winner;
          w_state_nxt = ST_RELEASE;
          w_req_nxt   = '0;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (r_cnt == CNT_W'(RELEASE_CYCLES - 1)) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        w_pid_nxt   = '0;
        w_pb_nxt    = 1'b0;
        w_gb_nxt    = 1'b0;
        w_clear     = 1'b1;
      end
    endcase
  end

  // State, counter and registered outputs; reset drops score_req immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_req   <= '0;
      r_pid   <= '0;
      r_pb    <= 1'b0;
      r_gb    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_req   <= w_req_nxt;
      r_pid   <= w_pid_nxt;
      r_pb    <= w_pb_nxt;
      r_gb    <= w_gb_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign score_req         = r_req;
  assign playerID          = r_pid;
  assign busy              = (r_state != ST_IDLE);
  assign new_personal_best = r_pb;
  assign new_global_best   = r_gb;
  assign report_done       = r_done;
endmodule

// File: tb/tb_score_reporter.sv
// Directed bench for score_reporter: table of full games plus hand sequences
// for idle-ignored events and reset in the middle of a report.
module tb_score_reporter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        game_start = 1'b0, point_tick = 1'b0, game_over = 1'b0;
  logic        personal_winner = 1'b0, global_winner = 1'b0;
  logic [4:0]  player_id_in = '0;
  logic [3:0]  score_req;
  logic [4:0]  playerID;
  logic [13:0] Score;
  logic        busy, npb, ngb, report_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  id;
    int          ticks;
    bit          same;      // last tick shares its cycle with game_over
    bit          pw;
    bit          gw;
    logic [13:0] exp_score;
  } vec_t;

  vec_t vecs [5];

  always #5 clk = ~clk;

  score_reporter dut (
    .clk              (clk),
    .rst              (rst),
    .game_start       (game_start),
    .player_id_in     (player_id_in),
    .point_tick       (point_tick),
    .game_over        (game_over),
    .personal_winner  (personal_winner),
    .global_winner    (global_winner),
    .score_req        (score_req),
    .playerID         (playerID),
    .Score            (Score),
    .busy             (busy),
    .new_personal_best(npb),
    .new_global_best  (ngb),
    .report_done      (report_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic run_game(input vec_t v);
    // start
    game_start = 1'b1; player_id_in = v.id;
    @(negedge clk);
    game_start = 1'b0; player_id_in = ~v.id;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_score", 32'(Score), 32'd0);
    chk("start_id", 32'(playerID), 32'(v.id));
    chk("start_pb_clr", 32'(npb), 32'd0);
    chk("start_gb_clr", 32'(ngb), 32'd0);
    // play; a restart attempt mid-game must be ignored
    for (int i = 0; i < v.ticks; i++) begin
      point_tick = 1'b1;
      game_start = (v.ticks > 3 && i == 2);
      game_over  = (v.same && i == v.ticks - 1);
      @(negedge clk);
    end
    point_tick = 1'b0; game_start = 1'b0;
    if (!v.same) begin
      chk("live_score", 32'(Score), 32'(v.exp_score));
      game_over = 1'b1;
      @(negedge clk);
    end
    game_over = 1'b0;
    // hold window: verdict inputs wrong early, correct from cycle 9
    for (int c = 0; c < 12; c++) begin
      chk("hold_req", 32'(score_req), 32'd5);
      chk("hold_score", 32'(Score), 32'(v.exp_score));
      chk("hold_id", 32'(playerID), 32'(v.id));
      chk("hold_busy", 32'(busy), 32'd1);
      personal_winner = (c >= 8) ? v.pw : ~v.pw;
      global_winner   = (c >= 8) ? v.gw : ~v.gw;
      game_start = (c == 3);
      point_tick = (c == 3 || c == 5);
      @(negedge clk);
    end
    game_start = 1'b0; point_tick = 1'b0;
    personal_winner = ~v.pw; global_winner = ~v.gw;
    // release
    chk("rel0_req", 32'(score_req), 32'd0);
    chk("rel0_pb", 32'(npb), 32'(v.pw));
    chk("rel0_gb", 32'(ngb), 32'(v.gw));
    chk("rel0_done", 32'(report_done), 32'd0);
    chk("rel0_score", 32'(Score), 32'(v.exp_score));
    @(negedge clk);
    chk("rel1_req", 32'(score_req), 32'd0);
    chk("rel1_busy", 32'(busy), 32'd1);
    chk("rel1_done", 32'(report_done), 32'd0);
    @(negedge clk);
    chk("done_pulse", 32'(report_done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_req", 32'(score_req), 32'd0);
    @(negedge clk);
    chk("done_single", 32'(report_done), 32'd0);
    chk("idle_pb_hold", 32'(npb), 32'(v.pw));
    chk("idle_gb_hold", 32'(ngb), 32'(v.gw));
    chk("idle_id_hold", 32'(playerID), 32'(v.id));
    personal_winner = 1'b0; global_winner = 1'b0;
  endtask

  initial begin
    vecs[0] = '{id: 5'd3,  ticks: 7,     same: 1'b0, pw: 1'b0, gw: 1'b0, exp_score: 14'd7};
    vecs[1] = '{id: 5'd3,  ticks: 7,     same: 1'b0, pw: 1'b1, gw: 1'b0, exp_score: 14'd7};
    vecs[2] = '{id: 5'd17, ticks: 0,     same: 1'b0, pw: 1'b0, gw: 1'b1, exp_score: 14'd0};
    vecs[3] = '{id: 5'd31, ticks: 42,    same: 1'b1, pw: 1'b1, gw: 1'b1, exp_score: 14'd42};
    vecs[4] = '{id: 5'd0,  ticks: 10005, same: 1'b0, pw: 1'b1, gw: 1'b0, exp_score: 14'd9999};

    repeat (2) @(negedge clk);
    chk("rst_req", 32'(score_req), 32'd0);
    chk("rst_id", 32'(playerID), 32'd0);
    chk("rst_score", 32'(Score), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pb", 32'(npb), 32'd0);
    chk("rst_gb", 32'(ngb), 32'd0);
    chk("rst_done", 32'(report_done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // ticks and game_over in IDLE do nothing
    point_tick = 1'b1; game_over = 1'b1;
    @(negedge clk);
    point_tick = 1'b0; game_over = 1'b0;
    @(negedge clk);
    chk("idle_ign_busy", 32'(busy), 32'd0);
    chk("idle_ign_req", 32'(score_req), 32'd0);
    chk("idle_ign_score", 32'(Score), 32'd0);

    foreach (vecs[i]) run_game(vecs[i]);

    // reset in the middle of HOLD
    game_start = 1'b1; player_id_in = 5'd9;
    @(negedge clk);
    game_start = 1'b0;
    repeat (5) begin point_tick = 1'b1; @(negedge clk); end
    point_tick = 1'b0; game_over = 1'b1;
    @(negedge clk);
    game_over = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_hold_req", 32'(score_req), 32'd5);
    #2 rst = 1'b1;
    #1;
    chk("arst_req", 32'(score_req), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_score", 32'(Score), 32'd0);
    chk("arst_id", 32'(playerID), 32'd0);
    chk("arst_pb", 32'(npb), 32'd0);
    chk("arst_gb", 32'(ngb), 32'd0);
    chk("arst_done", 32'(report_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    game_start = 1'b1; player_id_in = 5'd4;
    @(negedge clk);
    game_start = 1'b0;
    repeat (2) begin point_tick = 1'b1; @(negedge clk); end
    point_tick = 1'b0;
    chk("post_rst_id", 32'(playerID), 32'd4);
    chk("post_rst_score", 32'(Score), 32'd2);
    chk("post_rst_busy", 32'(busy), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
